spi_3wire_responder: RTL and testbench

//  3-wire SPI responder (slave) for our GSensor-style SPI link: the far end of the SDIO master.

---
 rtl/spi_3wire_responder_pkg.sv | 21 ++
 rtl/spi_3wire_responder_in_sync.sv | 37 +++
 rtl/spi_3wire_responder.sv | 161 ++++++++++++++++
 tb/tb_spi_3wire_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_3wire_responder_pkg.sv
// Shared definitions for the 3-wire SPI responder: FSM states and address-byte layout.
// No logic, so no latency and no backpressure.
package spi_3wire_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int RW_BIT   = 7;
    localparam int MB_BIT   = 6;
    localparam int BYTE_LEN = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_3wire_responder_in_sync.sv
// Synchronizer for one async SPI pin plus edge detect; latency STAGES iCLK to o_q, +0 to edges.
// No backpressure; o_vld rises once the chain holds real pin samples instead of reset presets.
module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic iCLK,
    input  logic iRSTN,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall,
    output logic o_vld
);

    logic [STAGES-1:0] r_sync;
    logic [STAGES-1:0] r_vld;
    logic              r_prev;

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            r_sync <= {STAGES{RST_VAL}};
            r_vld  <= '0;
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_vld  <= {r_vld[STAGES-2:0], 1'b1};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_vld  = r_vld[STAGES-1];
    assign o_rise = o_q & ~r_prev;
    assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_3wire_responder.sv
// 3-wire SPI responder: SDIO frames to 1-cycle register strobes, read data driven back on SDIO.
// Strobes ~3 iCLK after the sampling SCLK edge; no backpressure, register file must keep up.
module spi_3wire_responder
    import spi_3wire_responder_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              iCLK,
    input  logic              iRSTN,
    input  logic              SPI_SCLK,
    input  logic              SPI_CSN,
    inout  wire               SPI_SDIO,
    output logic [ADDR_W-1:0] oREG_ADDR,
    output logic [DATA_W-1:0] oREG_WDATA,
    output logic              oREG_WE,
    output logic              oREG_RE,
    input  logic [DATA_W-1:0] iREG_RDATA,
    output logic              oBUSY,
    output logic              oFRAME_END
);

    localparam int SHIFT_W = max_int(BYTE_LEN, DATA_W);
    localparam int CNT_W   = $clog2(SHIFT_W + 1);

    logic w_sclk_q, w_sclk_rise, w_sclk_fall, w_sclk_vld;
    logic w_csn_q, w_csn_rise, w_csn_fall, w_csn_vld;
    logic w_sdio_q, w_sdio_rise, w_sdio_fall, w_sdio_vld;
    logic w_unused;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .iCLK(iCLK), .iRSTN(iRSTN), .i_d(SPI_SCLK),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall), .o_vld(w_sclk_vld)
    );
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .iCLK(iCLK), .iRSTN(iRSTN), .i_d(SPI_CSN),
        .o_q(w_csn_q), .o_rise(w_csn_rise), .o_fall(w_csn_fall), .o_vld(w_csn_vld)
    );
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sdio (
        .iCLK(iCLK), .iRSTN(iRSTN), .i_d(SPI_SDIO),
        .o_q(w_sdio_q), .o_rise(w_sdio_rise), .o_fall(w_sdio_fall), .o_vld(w_sdio_vld)
    );

    state_t              r_state, w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [SHIFT_W-1:0]  r_rx;
    logic [SHIFT_W-1:0]  w_rx_next;
    logic [DATA_W-1:0]   r_tx, r_wdata;
    logic [ADDR_W-1:0]   r_addr, r_reg_addr;
    logic                r_mb, r_oe, r_we, r_re, r_load, r_frame_end, r_armed;
    logic                w_csn_end, w_start, w_last_addr, w_last_data, w_rw;

    assign w_rx_next   = {r_rx[SHIFT_W-2:0], w_sdio_q};
    assign w_rw        = w_rx_next[RW_BIT];
    assign w_csn_end   = (r_state != ST_IDLE) && w_csn_rise;
    // A CSN already low when reset releases never arms: a real high must be seen first.
    assign w_start     = (r_state == ST_IDLE) && r_armed && w_csn_fall;
    assign w_last_addr = w_sclk_rise && (r_cnt == CNT_W'(BYTE_LEN - 1));
    assign w_last_data = w_sclk_rise && (r_cnt == CNT_W'(DATA_W - 1));
    assign w_unused    = &{w_sclk_q, w_sclk_vld, w_sdio_rise, w_sdio_fall, w_sdio_vld, r_rx[SHIFT_W-1]};

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next_state = ST_ADDR;
            ST_ADDR:  if (w_csn_end) w_next_state = ST_IDLE;
                      else if (w_last_addr) w_next_state = w_rw ? ST_RDATA : ST_WDATA;
            ST_WDATA, ST_RDATA:
                      if (w_csn_end) w_next_state = ST_IDLE;
                      else if (w_last_data && !r_mb) w_next_state = ST_DONE;
            ST_DONE:  if (w_csn_end) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            r_cnt <= '0; r_rx <= '0; r_tx <= '0; r_wdata <= '0;
            r_addr <= '0; r_reg_addr <= '0; r_mb <= 1'b0; r_oe <= 1'b0;
            r_we <= 1'b0; r_re <= 1'b0; r_load <= 1'b0; r_frame_end <= 1'b0; r_armed <= 1'b0;
        end else begin
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_frame_end <= 1'b0;
            r_load      <= r_re;
            if (w_csn_vld && w_csn_q) r_armed <= 1'b1;
            if (w_csn_end) begin
                r_oe        <= 1'b0;
                r_frame_end <= 1'b1;
                r_cnt       <= '0;
                r_load      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_start) r_cnt <= '0;
                    ST_ADDR: if (w_sclk_rise) begin
                        r_rx  <= w_rx_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last_addr) begin
                            r_cnt  <= '0;
                            r_mb   <= w_rx_next[MB_BIT];
                            r_addr <= w_rx_next[ADDR_W-1:0];
                            if (w_rw) begin
                                r_re       <= 1'b1;
                                r_oe       <= 1'b1;
                                r_reg_addr <= w_rx_next[ADDR_W-1:0];
                            end
                        end
                    end
                    ST_WDATA: if (w_sclk_rise) begin
                        r_rx  <= w_rx_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last_data) begin
                            r_cnt      <= '0;
                            r_we       <= 1'b1;
                            r_reg_addr <= r_addr;
                            r_wdata    <= w_rx_next[DATA_W-1:0];
                            r_addr     <= r_addr + ADDR_W'(1);
                        end
                    end
                    ST_RDATA: begin
                        // The falling edge right after a load must keep tx[MSB] on the wire.
                        if (w_sclk_fall && (r_cnt != '0)) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                        if (w_sclk_rise) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            if (w_last_data) begin
                                r_cnt <= '0;
                                if (r_mb) begin
                                    r_addr     <= r_addr + ADDR_W'(1);
                                    r_reg_addr <= r_addr + ADDR_W'(1);
                                    r_re       <= 1'b1;
                                end else begin
                                    r_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
                if (r_load) r_tx <= iREG_RDATA;
            end
        end
    end

    always_comb begin
        oBUSY      = (r_state != ST_IDLE);
        oREG_WE    = r_we;
        oREG_RE    = r_re;
        oREG_ADDR  = r_reg_addr;
        oREG_WDATA = r_wdata;
        oFRAME_END = r_frame_end;
    end

    assign SPI_SDIO = r_oe ? r_tx[DATA_W-1] : 1'bz;

endmodule

// File: tb/tb_spi_3wire_responder.sv
// Bench for spi_3wire_responder: a master model drives frames, a register-file model answers
// strobes, and expected strobes/read bytes are derived per frame from the address-byte rules.
`timescale 1ns/1ps
module tb_spi_3wire_responder;

    localparam int HALF = 8;

    typedef struct packed {
        logic       we;
        logic [5:0] addr;
        logic [7:0] data;
    } strobe_t;

    logic       iCLK = 1'b0;
    logic       iRSTN = 1'b0;
    logic       SPI_SCLK = 1'b1;
    logic       SPI_CSN = 1'b1;
    logic       m_oe = 1'b0;
    logic       m_dat = 1'b0;
    wire        sdio;
    logic [5:0] oREG_ADDR;
    logic [7:0] oREG_WDATA;
    logic [7:0] rdata;
    logic       oREG_WE, oREG_RE, oBUSY, oFRAME_END;

    assign sdio = m_oe ? m_dat : 1'bz;

    spi_3wire_responder #(.ADDR_W(6), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .iCLK(iCLK), .iRSTN(iRSTN), .SPI_SCLK(SPI_SCLK), .SPI_CSN(SPI_CSN), .SPI_SDIO(sdio),
        .oREG_ADDR(oREG_ADDR), .oREG_WDATA(oREG_WDATA), .oREG_WE(oREG_WE), .oREG_RE(oREG_RE),
        .iREG_RDATA(rdata), .oBUSY(oBUSY), .oFRAME_END(oFRAME_END)
    );

    always #5 iCLK = ~iCLK;

    logic [7:0] regs [64];
    logic [7:0] preset [64];
    logic [7:0] model [64];
    logic [7:0] wbuf [8];
    logic [7:0] rd_got [8];
    logic       do_preset = 1'b0;
    strobe_t    exp_q [$];
    int         vectors = 0;
    int         miscompares = 0;
    int         fe_cnt = 0;

    // Register file on the far side of the strobes; read data appears one cycle after oREG_RE.
    always @(posedge iCLK) begin
        if (do_preset) begin
            for (int i = 0; i < 64; i++) regs[i] <= preset[i];
        end else if (oREG_WE) begin
            regs[oREG_ADDR] <= oREG_WDATA;
        end
        if (oREG_RE) rdata <= regs[oREG_ADDR];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic we, input logic [5:0] addr, input logic [7:0] data);
        strobe_t s;
        s.we = we; s.addr = addr; s.data = data;
        exp_q.push_back(s);
    endtask

    // Every cycle advance goes through here, so strobes are compared on every cycle.
    task automatic tick(input int n);
        strobe_t got, e;
        for (int c = 0; c < n; c++) begin
            @(negedge iCLK);
            if (iRSTN) begin
                if (oREG_WE || oREG_RE) begin
                    got.we = oREG_WE; got.addr = oREG_ADDR; got.data = oREG_WE ? oREG_WDATA : 8'h00;
                    chk("we_re_exclusive", {31'd0, oREG_WE & oREG_RE}, 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", {30'd0, oREG_WE, oREG_RE}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe", {17'd0, got}, {17'd0, e});
                    end
                end
                if (oFRAME_END) fe_cnt++;
            end
        end
    endtask

    task automatic bit_out(input logic b);
        SPI_SCLK = 1'b0; m_oe = 1'b1; m_dat = b;
        tick(HALF);
        chk("sdio_oe_master_phase", {31'd0, dut.r_oe}, 32'd0);
        SPI_SCLK = 1'b1;
        tick(1);
        m_oe = 1'b0;
        tick(HALF - 1);
    endtask

    task automatic bit_in(output logic b, input logic exp_oe);
        SPI_SCLK = 1'b0; m_oe = 1'b0;
        tick(HALF);
        chk("sdio_oe_read_phase", {31'd0, dut.r_oe}, {31'd0, exp_oe});
        b = sdio;
        SPI_SCLK = 1'b1;
        tick(HALF);
    endtask

    // abort_bits < 0 clocks every data bit; otherwise CSN rises after that many data bits.
    task automatic frame(input logic rw, input logic mb, input logic [5:0] a,
                         input int nbytes, input int abort_bits);
        int         bits, full, nstrobe, fe0;
        logic [7:0] hdr, rb;
        logic [5:0] ai;
        logic       b;
        bits = (abort_bits < 0) ? nbytes * 8 : abort_bits;
        full = bits / 8;
        if (!rw) begin
            nstrobe = mb ? full : ((full > 0) ? 1 : 0);
            for (int i = 0; i < nstrobe; i++) begin
                ai = a + 6'(i);
                push_exp(1'b1, ai, wbuf[i]);
                model[ai] = wbuf[i];
            end
        end else begin
            push_exp(1'b0, a, 8'h00);
            if (mb) for (int i = 0; i < full; i++) push_exp(1'b0, a + 6'(i + 1), 8'h00);
        end
        fe0 = fe_cnt;
        hdr = {rw, mb, a};
        SPI_CSN = 1'b0;
        tick(HALF);
        for (int i = 7; i >= 0; i--) bit_out(hdr[i]);
        chk("busy_in_frame", {31'd0, oBUSY}, 32'd1);
        rb = 8'h00;
        for (int k = 0; k < bits; k++) begin
            if (!rw) begin
                bit_out(wbuf[k / 8][7 - (k % 8)]);
            end else begin
                bit_in(b, 1'b1);
                rb = {rb[6:0], b};
                if (k % 8 == 7) begin
                    ai = a + 6'(k / 8);
                    rd_got[k / 8] = rb;
                    chk("read_byte", {24'd0, rb}, {24'd0, model[ai]});
                end
            end
        end
        tick(HALF);
        SPI_CSN = 1'b1;
        tick(HALF + 4);
        chk("frame_end_pulses", fe_cnt - fe0, 32'd1);
        chk("busy_after_frame", {31'd0, oBUSY}, 32'd0);
        chk("sdio_released", {31'd0, dut.r_oe}, 32'd0);
        chk("strobes_pending", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic       b;
        logic [7:0] h;
        logic       rw, mb;
        logic [5:0] a;
        int         n, ab;

        for (int i = 0; i < 64; i++) preset[i] = 8'($urandom);
        preset[6'h00] = 8'hE5;
        for (int i = 0; i < 6; i++) preset[6'h32 + i] = 8'h10 + 8'(i);
        model = preset;

        do_preset = 1'b1;
        tick(3);
        do_preset = 1'b0;
        chk("reset_we", {31'd0, oREG_WE}, 32'd0);
        chk("reset_re", {31'd0, oREG_RE}, 32'd0);
        chk("reset_busy", {31'd0, oBUSY}, 32'd0);
        chk("reset_frame_end", {31'd0, oFRAME_END}, 32'd0);
        chk("reset_addr_wdata", {18'd0, oREG_ADDR, oREG_WDATA}, 32'd0);
        chk("reset_oe", {31'd0, dut.r_oe}, 32'd0);
        iRSTN = 1'b1;
        tick(6);

        wbuf[0] = 8'h08;
        frame(1'b0, 1'b0, 6'h2D, 1, -1);
        chk("t1_reg_2d", {24'd0, regs[6'h2D]}, 32'h08);

        frame(1'b1, 1'b0, 6'h00, 1, -1);
        chk("t2_read_e5", {24'd0, rd_got[0]}, 32'hE5);

        frame(1'b1, 1'b1, 6'h32, 6, -1);
        chk("t3_first_byte", {24'd0, rd_got[0]}, 32'h10);
        chk("t3_last_byte", {24'd0, rd_got[5]}, 32'h15);

        wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
        frame(1'b0, 1'b1, 6'h3F, 2, -1);
        chk("t4_reg_3f", {24'd0, regs[6'h3F]}, 32'hAA);
        chk("t4_reg_00_wrap", {24'd0, regs[6'h00]}, 32'h55);

        wbuf[0] = 8'hC3;
        frame(1'b0, 1'b0, 6'h11, 1, 4);
        chk("t5_partial_dropped", {24'd0, regs[6'h11]}, {24'd0, model[6'h11]});

        // Reset mid-read with CSN held low: bus released, no frame until CSN cycles.
        h = {1'b1, 1'b0, 6'h10};
        push_exp(1'b0, 6'h10, 8'h00);
        SPI_CSN = 1'b0;
        tick(HALF);
        for (int i = 7; i >= 0; i--) bit_out(h[i]);
        for (int i = 0; i < 3; i++) bit_in(b, 1'b1);
        SPI_SCLK = 1'b0;
        tick(2);
        #2 iRSTN = 1'b0;
        #1;
        chk("t6_oe_in_reset", {31'd0, dut.r_oe}, 32'd0);
        chk("t6_busy_in_reset", {31'd0, oBUSY}, 32'd0);
        tick(4);
        iRSTN = 1'b1;
        tick(4);
        h = {1'b0, 1'b0, 6'h05};
        for (int i = 7; i >= 0; i--) bit_out(h[i]);
        h = 8'h77;
        for (int i = 7; i >= 0; i--) bit_out(h[i]);
        tick(HALF);
        chk("t6_busy_not_rearmed", {31'd0, oBUSY}, 32'd0);
        chk("t6_strobes_pending", exp_q.size(), 32'd0);
        SPI_CSN = 1'b1;
        tick(HALF);
        wbuf[0] = 8'h77;
        frame(1'b0, 1'b0, 6'h05, 1, -1);
        chk("t6_reg_05_after_rearm", {24'd0, regs[6'h05]}, 32'h77);

        for (int f = 0; f < 30; f++) begin
            rw = 1'($urandom % 2);
            mb = 1'($urandom % 2);
            a  = 6'($urandom);
            n  = mb ? 1 + int'($urandom % 4) : (rw ? 1 : 1 + int'($urandom % 2));
            ab = -1;
            if ($urandom % 5 == 0) ab = 1 + int'($urandom % 32'(n * 8 - 1));
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
            frame(rw, mb, a, n, ab);
        end

        for (int i = 0; i < 64; i++) chk("final_regfile", {24'd0, regs[i]}, {24'd0, model[i]});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
